alu_arbiter: RTL
================

# alu_arbiter

Shares one combinational `alu` instance between two requesters, each with its own valid/ready request and response channel. A round-robin grant selects one request at a time. The block latches that request's operands, evaluates them in the ALU for one cycle, and holds the registered result until the owning requester accepts it. It sits between the two requesting units (e.g. address-generation and execute stages of the multi-cycle CPU) and the single ALU.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; must match the `alu` instance.

Ports (`n` ∈ {0,1}; one set per requester):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqn_valid`  in  1  requester n presents an operation.
- `reqn_ready`  out  1  operation accepted this cycle.
- `reqn_A`, `reqn_B`  in  `DATA_WIDTH`  operands.
- `reqn_ALUop`  in  3  opcode: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- `respn_valid`  out  1  result for requester n available.
- `respn_ready`  in  1  requester n takes the result.
- `respn_Result`  out  `DATA_WIDTH`  ALU result.
- `respn_flags`  out  3  {Overflow, CarryOut, Zero}.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant: if only one `reqn_valid` is high, grant n. If both are high, grant the port named by the round-robin pointer `rr`.
  - `reqn_ready` = (state==IDLE) && grant==n. It is combinational and never high for both ports.
  - On handshake: latch A, B, ALUop and the granted port id; go to EXEC.
- **EXEC:**
  - The ALU evaluates the latched operands.
  - On this edge, capture Result and flags into the response registers of the granted port; go to RESP.
- **RESP:**
  - `respn_valid`=1 for the granted port only; outputs hold stable.
  - On `respn_ready`: drop valid, set `rr` to the other port, go to IDLE.
  - `rr` also flips after a non-contended grant.
- Flag masking:
  - Overflow and CarryOut are meaningful only for ADD and SUB; forced to 0 for AND, OR, SLT.
  - CarryOut on SUB is the unsigned borrow (1 iff A < B unsigned).
  - Zero is always valid.
- Illegal ALUop (011, 100, 101): accepted normally; Result=0, flags=0. Never propagate X.
- Requesters hold valid and operands stable until ready (standard rule). The block does not check this.
- The non-granted port's `resp_valid` stays 0; its last response data is held.

## Timing
- Request accepted at edge T → `respn_valid` high from T+2.
- Minimum three cycles per operation (IDLE→EXEC→RESP→IDLE); throughput 1/3.
- `respn_ready` already high when valid rises → IDLE at T+3; the next grant can handshake in cycle T+3.
- While RESP is stalled by backpressure, both `reqn_ready` stay 0 and no new operand latch occurs.
- Reset values: state=IDLE, `rr`=0 (port 0 preferred), both `reqn_ready`=0, both `respn_valid`=0, all Result/flags registers 0.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded with no response. After release, IDLE and grant priority are as from power-up.

## Structure
- A shared header (`alu_defs.vh`) holds the ALUop codes (AND/OR/ADD/SUB/SLT), `DATA_WIDTH`, and the FSM state encoding (2 bits: IDLE 00, EXEC 01, RESP 10).
- One sub-module: a single `alu` instance, fed from the latched operand registers only (never directly from the request ports).
- Flag masking and illegal-op zeroing live in the arbiter, after the ALU.

## Test plan
- Port 0 ADD A=0x7FFFFFFF, B=0x00000001 → `resp0_Result`=0x80000000, flags={1,0,0}, `resp0_valid` exactly 2 cycles after handshake.
- Both ports valid in the same cycle after reset: port 0 SUB 5−5, port 1 SUB 3−5 → port 0 served first with Result 0, flags={0,0,1}. Then port 1 with Result 0xFFFFFFFE, flags={0,1,0}. Next contention grants port 0 again.
- Port 1 SLT A=0xFFFFFFFF (−1), B=1 → Result 0x00000001, flags={0,0,0}.
- `resp0_ready` held low 4 cycles with `req1_valid` high → `resp0_valid`/Result stable and `req1_ready`=0 throughout. Port 1 is granted the cycle after the `resp0` handshake.
- Illegal op 3'b100 on port 0 with arbitrary operands → Result 0, flags {0,0,0}; no X on any output.
- `rst` pulsed during EXEC → no `resp_valid` on either port; all outputs 0 immediately (asynchronous). The first request after release completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding,
// flag bundle layout and default operand width.
package alu_arbiter_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic overflow;
    logic carry_out;
    logic zero;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic has_arith_flags(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU: AND, OR, ADD, SUB, SLT with raw overflow,
// carry/borrow and zero flags. Unknown opcodes produce a zero result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            alu_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out,
  output logic                  zero
);

  logic                  sub_mode;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum_ext;
  logic                  add_overflow;
  logic                  signed_less;

  // SUB and SLT share one adder as a + ~b + 1; the carry out of that adder
  // is the inverse of the unsigned borrow.
  always_comb begin
    sub_mode     = (alu_op == ALU_SUB) || (alu_op == ALU_SLT);
    b_eff        = sub_mode ? ~b : b;
    sum_ext      = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_mode};
    add_overflow = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                   (sum_ext[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    signed_less  = sum_ext[DATA_WIDTH-1] ^ add_overflow;
  end

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result    = sum_ext[DATA_WIDTH-1:0];
        overflow  = add_overflow;
        carry_out = sum_ext[DATA_WIDTH];
      end
      ALU_SUB: begin
        result    = sum_ext[DATA_WIDTH-1:0];
        overflow  = add_overflow;
        carry_out = ~sum_ext[DATA_WIDTH];
      end
      ALU_SLT: begin
        result    = {{(DATA_WIDTH-1){1'b0}}, signed_less};
        overflow  = add_overflow;
        carry_out = ~sum_ext[DATA_WIDTH];
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// each operation runs IDLE -> EXEC -> RESP with a registered, held response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_ALUop,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_Result,
  output logic [2:0]            resp0_flags,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_ALUop,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_Result,
  output logic [2:0]            resp1_flags
);

  state_e                state;
  logic                  owner;
  logic                  rr;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [2:0]            op_code;

  logic                  grant_valid;
  logic                  grant;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic                  alu_carry;
  logic                  alu_zero;

  logic [DATA_WIDTH-1:0] masked_result;
  alu_flags_t            masked_flags;

  // A lone requester wins outright; contention is settled by the rr pointer.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = rr;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = !rst && (state == IDLE) && grant_valid && !grant;
  assign req1_ready = !rst && (state == IDLE) && grant_valid &&  grant;

  alu_arbiter_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) alu (
    .a         (op_a),
    .b         (op_b),
    .alu_op    (op_code),
    .result    (alu_result),
    .overflow  (alu_overflow),
    .carry_out (alu_carry),
    .zero      (alu_zero)
  );

  // Carry and overflow only mean something for ADD/SUB; illegal ops read as all-zero.
  always_comb begin
    masked_result          = is_legal_op(op_code) ? alu_result : '0;
    masked_flags.overflow  = has_arith_flags(op_code) & alu_overflow;
    masked_flags.carry_out = has_arith_flags(op_code) & alu_carry;
    masked_flags.zero      = is_legal_op(op_code) & alu_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      rr           <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_code      <= '0;
      resp0_valid  <= 1'b0;
      resp0_Result <= '0;
      resp0_flags  <= '0;
      resp1_valid  <= 1'b0;
      resp1_Result <= '0;
      resp1_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant;
            op_a    <= grant ? req1_A     : req0_A;
            op_b    <= grant ? req1_B     : req0_B;
            op_code <= grant ? req1_ALUop : req0_ALUop;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            resp1_Result <= masked_result;
            resp1_flags  <= masked_flags;
            resp1_valid  <= 1'b1;
          end else begin
            resp0_Result <= masked_result;
            resp0_flags  <= masked_flags;
            resp0_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          // The port just served drops to lowest priority for the next contention.
          if (owner ? resp1_ready : resp0_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            rr          <= ~owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
